vx_axi_read_credit_sched: RTL and testbench

Credit-based read-request scheduler placed between NUM_REQS AXI read requesters and the input side of the AXI read memory arbiter. It admits at most one AR burst per cycle, chosen round-robin, only when the shared response buffer has room for all `arlen+1` beats and the requester is below its outstanding-burst limit. Credits are returned as R beats are consumed. A starvation lock prevents short bursts from indefinitely blocking a long burst.

---
 rtl/vx_axi_read_credit_sched.sv | 119 +++++++++++
 tb/tb_vx_axi_read_credit_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_axi_read_credit_sched.sv
// vx_axi_read_credit_sched: credit-based round-robin AR admission with grant hold and starvation lock
// Ports: req_arvalid/req_arlen/req_arready - requester AR side; arb_arvalid/arb_arready - arbiter inputs;
//        rsp_fire/rsp_last - R beats consumed per requester; credits/outstanding/idle/err - status.
module vx_axi_read_credit_sched #(
  parameter int NUM_REQS = 2,
  parameter int RSP_BEATS = 64,
  parameter int MAX_BURSTS = 4,
  parameter int STARVE_LIMIT = 16,
  localparam int CW = $clog2(RSP_BEATS+1),
  localparam int BW = $clog2(MAX_BURSTS+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_arvalid,
  input  logic [NUM_REQS-1:0][7:0]      req_arlen,
  output logic [NUM_REQS-1:0]           req_arready,
  output logic [NUM_REQS-1:0]           arb_arvalid,
  input  logic [NUM_REQS-1:0]           arb_arready,
  input  logic [NUM_REQS-1:0]           rsp_fire,
  input  logic [NUM_REQS-1:0]           rsp_last,
  output logic [CW-1:0]                 credits,
  output logic [NUM_REQS-1:0][BW-1:0]   outstanding,
  output logic                          idle,
  output logic                          err
);
  localparam int IW = $clog2(NUM_REQS);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [IW-1:0] rr_ptr, hold_idx, lock_idx, low_sat, pick, gnt, eff_lock_idx;
  logic hold_vld, lock_vld, any_sat, eff_lock_vld, pick_vld, gnt_vld, fire;
  logic [NUM_REQS-1:0] credit_ok, size_ok, slot_ok, lock_ok, elig, starve_inc, zero_out, ret;
  logic [SW-1:0] starve [NUM_REQS];
  logic [CW-1:0] credits_nxt;
  int pop, c_sum;
  always_comb begin
    any_sat = 1'b0;
    low_sat = '0;
    for (int i = NUM_REQS-1; i >= 0; i--)
      if (starve[i] == SW'(STARVE_LIMIT)) begin
        any_sat = 1'b1;
        low_sat = IW'(i);
      end
  end
  // A saturated counter grabs the lock in the same cycle it saturates.
  assign eff_lock_vld = lock_vld | any_sat;
  assign eff_lock_idx = lock_vld ? lock_idx : low_sat;
  always_comb begin
    credit_ok = '0;
    size_ok = '0;
    slot_ok = '0;
    lock_ok = '0;
    elig = '0;
    starve_inc = '0;
    zero_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      credit_ok[i] = int'(req_arlen[i]) + 1 <= int'(credits);
      size_ok[i] = int'(req_arlen[i]) < RSP_BEATS;
      slot_ok[i] = int'(outstanding[i]) < MAX_BURSTS;
      lock_ok[i] = !eff_lock_vld || eff_lock_idx == IW'(i);
      zero_out[i] = outstanding[i] == '0;
      elig[i] = req_arvalid[i] & credit_ok[i] & slot_ok[i] & lock_ok[i];
      // Oversized bursts can never be satisfied, so they must not take the lock.
      starve_inc[i] = req_arvalid[i] & ~credit_ok[i] & size_ok[i] & slot_ok[i] & lock_ok[i];
    end
  end
  always_comb begin
    pick_vld = 1'b0;
    pick = '0;
    for (int k = NUM_REQS-1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_REQS]) begin
        pick_vld = 1'b1;
        pick = IW'((int'(rr_ptr) + k) % NUM_REQS);
      end
  end
  assign gnt_vld = ~reset & (hold_vld | pick_vld);
  assign gnt = hold_vld ? hold_idx : pick;
  assign fire = gnt_vld & arb_arready[gnt];
  assign ret = rsp_fire & rsp_last;
  always_comb begin
    arb_arvalid = '0;
    req_arready = '0;
    arb_arvalid[gnt] = gnt_vld;
    req_arready[gnt] = gnt_vld & arb_arready[gnt];
  end
  always_comb begin
    pop = 0;
    for (int i = 0; i < NUM_REQS; i++) pop += int'(rsp_fire[i]);
    c_sum = int'(credits) + pop - (fire ? int'(req_arlen[gnt]) + 1 : 0);
    credits_nxt = c_sum > RSP_BEATS ? CW'(RSP_BEATS) : CW'(c_sum);
  end
  always_comb begin
    idle = credits == CW'(RSP_BEATS);
    for (int i = 0; i < NUM_REQS; i++) idle = idle & zero_out[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CW'(RSP_BEATS);
      outstanding <= '0;
      rr_ptr <= '0;
      hold_vld <= 1'b0;
      hold_idx <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      err <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) starve[i] <= '0;
    end else begin
      credits <= credits_nxt;
      for (int i = 0; i < NUM_REQS; i++) begin
        outstanding[i] <= outstanding[i] + BW'(fire && gnt == IW'(i)) - BW'(ret[i] && !zero_out[i]);
        starve[i] <= !starve_inc[i] ? '0 : (starve[i] == SW'(STARVE_LIMIT) ? starve[i] : starve[i] + 1'b1);
      end
      hold_vld <= gnt_vld & ~fire;
      hold_idx <= gnt;
      lock_vld <= eff_lock_vld & ~(fire && gnt == eff_lock_idx);
      lock_idx <= eff_lock_idx;
      if (fire) rr_ptr <= IW'((int'(gnt) + 1) % NUM_REQS);
      err <= err | (|rsp_fire && credits == CW'(RSP_BEATS)) | |(ret & zero_out) | |(req_arvalid & ~size_ok);
    end
  end
endmodule

// File: tb/tb_vx_axi_read_credit_sched.sv
// tb_vx_axi_read_credit_sched: table, directed and random checks against a burst-queue reference model
module tb_vx_axi_read_credit_sched;
  localparam int N = 2;
  localparam int RB = 64;
  localparam int MB = 4;
  localparam int SL = 16;
  localparam int CW = $clog2(RB+1);
  localparam int BW = $clog2(MB+1);
  typedef struct {
    logic [1:0] v;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [1:0] rdy;
    logic [1:0] rf;
    logic [1:0] rl;
    logic [1:0] ev;
    logic [1:0] er;
    int ec;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_arvalid, req_arready, arb_arvalid, arb_arready, rsp_fire, rsp_last;
  logic [N-1:0][7:0] req_arlen;
  logic [CW-1:0] credits;
  logic [N-1:0][BW-1:0] outstanding;
  logic idle, err;
  int total = 0;
  int bad = 0;
  int qb[N][8];
  int qn[N];
  int m_st[N];
  int dut_fires[N];
  int m_rr, m_hold, m_hold_len, m_lock;
  vec_t tbl[10];

  vx_axi_read_credit_sched #(.NUM_REQS(N), .RSP_BEATS(RB), .MAX_BURSTS(MB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .req_arvalid(req_arvalid), .req_arlen(req_arlen), .req_arready(req_arready),
    .arb_arvalid(arb_arvalid), .arb_arready(arb_arready), .rsp_fire(rsp_fire), .rsp_last(rsp_last),
    .credits(credits), .outstanding(outstanding), .idle(idle), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Free credits are whatever the in-flight bursts have not yet returned.
  function automatic int m_credits();
    int c = RB;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < qn[i]; k++) c -= qb[i][k];
    return c;
  endfunction

  function automatic int m_eff_lock();
    int r = m_lock;
    for (int i = N-1; i >= 0; i--) if (m_lock < 0 && m_st[i] == SL) r = i;
    return r;
  endfunction

  function automatic bit m_elig(int i, int c, int lk);
    return req_arvalid[i] && qn[i] < MB && int'(req_arlen[i]) + 1 <= c && (lk < 0 || lk == i);
  endfunction

  function automatic int m_grant();
    int c = m_credits();
    int lk = m_eff_lock();
    int r = -1;
    for (int k = N-1; k >= 0; k--) if (m_elig((m_rr + k) % N, c, lk)) r = (m_rr + k) % N;
    return m_hold >= 0 ? m_hold : r;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [1:0] rdy, input logic [1:0] rf, input logic [1:0] rl);
    req_arvalid = v;
    req_arlen[0] = l0;
    req_arlen[1] = l1;
    arb_arready = rdy;
    rsp_fire = rf;
    rsp_last = rl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      qn[i] = 0;
      m_st[i] = 0;
      dut_fires[i] = 0;
    end
    m_rr = 0;
    m_hold = -1;
    m_lock = -1;
    m_hold_len = 0;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One cycle of legal traffic: compare every output with the model, then advance both.
  task automatic step();
    int g, c, lk, busy;
    bit fire;
    logic [N-1:0] ev, er;
    #1;
    g = m_grant();
    c = m_credits();
    lk = m_eff_lock();
    ev = '0;
    er = '0;
    busy = 0;
    if (g >= 0) begin
      ev[g] = 1'b1;
      er[g] = arb_arready[g];
    end
    chk("arb_arvalid", int'(arb_arvalid), int'(ev));
    chk("req_arready", int'(req_arready), int'(er));
    chk("credits", int'(credits), c);
    for (int i = 0; i < N; i++) begin
      chk("outstanding", int'(outstanding[i]), qn[i]);
      busy += qn[i];
    end
    chk("idle", int'(idle), int'(c == RB && busy == 0));
    chk("err", int'(err), 0);
    for (int i = 0; i < N; i++) if (arb_arvalid[i] && arb_arready[i]) dut_fires[i]++;
    fire = g >= 0 && arb_arready[g];
    for (int i = 0; i < N; i++) begin
      if (req_arvalid[i] && qn[i] < MB && int'(req_arlen[i]) + 1 > c && int'(req_arlen[i]) < RB && (lk < 0 || lk == i))
        m_st[i] = m_st[i] < SL ? m_st[i] + 1 : SL;
      else
        m_st[i] = 0;
      if (rsp_fire[i] && qn[i] > 0) begin
        qb[i][0]--;
        if (qb[i][0] == 0) begin
          for (int k = 0; k < 7; k++) qb[i][k] = qb[i][k+1];
          qn[i]--;
        end
      end
    end
    if (fire) begin
      qb[g][qn[g]] = int'(req_arlen[g]) + 1;
      qn[g]++;
      m_rr = (g + 1) % N;
    end
    m_lock = (fire && g == lk) ? -1 : lk;
    m_hold = (g >= 0 && !fire) ? g : -1;
    if (m_hold >= 0) m_hold_len = int'(req_arlen[g]);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int found;
    logic [1:0] rf1;
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    model_clear();
    tbl[0] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 64};
    tbl[1] = '{2'b01, 8'd3, 8'd0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 64};
    tbl[2] = '{2'b11, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 60};
    tbl[3] = '{2'b11, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 59};
    tbl[4] = '{2'b11, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 58};
    tbl[5] = '{2'b11, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 58};
    tbl[6] = '{2'b11, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 58};
    tbl[7] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 57};
    tbl[8] = '{2'b01, 8'd3, 8'd0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 58};
    tbl[9] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 55};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].l0, tbl[k].l1, tbl[k].rdy, tbl[k].rf, tbl[k].rl);
      #1;
      chk("tbl_arvalid", int'(arb_arvalid), int'(tbl[k].ev));
      chk("tbl_arready", int'(req_arready), int'(tbl[k].er));
      chk("tbl_credits", int'(credits), tbl[k].ec);
      step();
    end

    // Credit bound: 16-beat bursts exhaust 64 credits after four grants.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      drive(2'b01, 8'd15, 8'd0, 2'b11, 2'b00, 2'b00);
      step();
    end
    #1;
    chk("bound_fires", dut_fires[0], 4);
    chk("bound_credits", int'(credits), 0);
    chk("bound_arvalid", int'(arb_arvalid), 0);

    // Hold stability: requester 1 stays presented while the arbiter stalls.
    do_reset();
    drive(2'b10, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    step();
    for (int n = 0; n < 4; n++) begin
      drive(2'b11, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
      #1;
      chk("hold_arvalid", int'(arb_arvalid), 2);
      step();
    end
    drive(2'b11, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00);
    #1;
    chk("hold_fire_arready", int'(req_arready), 2);
    step();
    drive(2'b11, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00);
    #1;
    chk("hold_next_arvalid", int'(arb_arvalid), 1);
    step();

    // Release arithmetic: a 4-beat fire alongside two returned beats nets -2.
    do_reset();
    drive(2'b01, 8'd1, 8'd0, 2'b01, 2'b00, 2'b00);
    step();
    drive(2'b10, 8'd0, 8'd0, 2'b10, 2'b00, 2'b00);
    step();
    drive(2'b10, 8'd0, 8'd3, 2'b10, 2'b11, 2'b10);
    #1;
    chk("rel_credits_before", int'(credits), 61);
    step();
    #1;
    chk("rel_credits_after", int'(credits), 59);
    chk("rel_out1", int'(outstanding[1]), 1);
    chk("rel_out0", int'(outstanding[0]), 1);

    // Starvation: a 32-beat request locks out a 1-beat streamer.
    do_reset();
    drive(2'b01, 8'd53, 8'd0, 2'b01, 2'b00, 2'b00);
    step();
    for (int n = 0; n < 20; n++) begin
      rf1 = {qn[1] > 0, 1'b0};
      drive(2'b11, 8'd31, 8'd0, 2'b11, rf1, rf1);
      step();
    end
    drive(2'b11, 8'd31, 8'd0, 2'b11, 2'b00, 2'b00);
    #1;
    chk("starve_block", int'(arb_arvalid), 0);
    chk("starve_credits", int'(credits), 10);
    step();
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      drive(2'b11, 8'd31, 8'd0, 2'b11, 2'b01, 2'b00);
      #1;
      if (arb_arvalid == 2'b01) begin
        found = 1;
        chk("starve_fire_credits", int'(credits), 32);
      end
      step();
    end
    chk("starve_fire_found", found, 1);

    // Random legal traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        req_arvalid[i] = $urandom_range(0, 3) != 0;
        req_arlen[i] = 8'($urandom_range(0, 20));
        rsp_fire[i] = qn[i] > 0 && $urandom_range(0, 1) == 1;
        rsp_last[i] = rsp_fire[i] && qb[i][0] == 1;
      end
      if (m_hold >= 0) begin
        req_arvalid[m_hold] = 1'b1;
        req_arlen[m_hold] = 8'(m_hold_len);
      end
      arb_arready = 2'($urandom_range(0, 3));
      step();
    end

    // Error: beat returned while all credits are free.
    do_reset();
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    #1;
    chk("err_overflow", int'(err), 1);
    chk("err_overflow_credits", int'(credits), 64);

    // Error: rlast on a requester with nothing outstanding.
    do_reset();
    drive(2'b10, 8'd0, 8'd0, 2'b10, 2'b00, 2'b00);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b01);
    #1;
    chk("err_last_pre", int'(err), 0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    #1;
    chk("err_last", int'(err), 1);
    chk("err_last_out0", int'(outstanding[0]), 0);

    // Error: burst larger than the buffer is never granted.
    do_reset();
    drive(2'b01, 8'd255, 8'd0, 2'b11, 2'b00, 2'b00);
    #1;
    chk("err_size_arvalid", int'(arb_arvalid), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("err_size", int'(err), 1);

    // Reset mid-burst with a held grant and a sticky error.
    drive(2'b10, 8'd0, 8'd7, 2'b10, 2'b00, 2'b00);
    @(posedge clk);
    @(negedge clk);
    drive(2'b10, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_pre_credits", int'(credits), 56);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_credits", int'(credits), 64);
    chk("mid_out0", int'(outstanding[0]), 0);
    chk("mid_out1", int'(outstanding[1]), 0);
    chk("mid_arvalid", int'(arb_arvalid), 0);
    chk("mid_arready", int'(req_arready), 0);
    chk("mid_idle", int'(idle), 1);
    chk("mid_err", int'(err), 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
